apb_bridge_xbar: RTL and testbench

- Parametrised, registered APB 1-to-N bridge. Successor to the fixed 4-target fabric: target count and address map are parameters.
- Adds behaviour the fixed fabric lacks: decode-miss error response, per-transfer timeout abort, and a status pulse for both.
- Sits between core_top's APB initiator port and the peripherals (ram, uart_top, mtimer, plic_top, future targets). One transfer in flight.

---
 rtl/apb_bridge_pkg.sv | 40 ++++
 rtl/apb_addr_decode.sv | 31 +++
 rtl/apb_bridge_xbar.sv | 170 +++++++++++++++++
 tb/tb_apb_bridge_xbar.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared types and the address-decode helper for the parametrised APB bridge.
package apb_bridge_pkg;

  localparam int TGT_MAX = 16;
  localparam int IDX_W   = 4;

  localparam int ERR_MISS = 0;
  localparam int ERR_TMO  = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    T_SETUP  = 2'd1,
    T_ACCESS = 2'd2,
    RESP     = 2'd3
  } state_t;

  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } dec_t;

  // Walk from the top index down so the lowest matching target wins.
  function automatic dec_t addr_decode(
    input logic [31:0]                addr,
    input logic [TGT_MAX-1:0][31:0]   base,
    input logic [TGT_MAX-1:0][31:0]   mask,
    input int                         n
  );
    dec_t d;
    d = '0;
    for (int k = TGT_MAX - 1; k >= 0; k--) begin
      if (k < n && (addr & ~mask[k]) == base[k]) begin
        d.hit = 1'b1;
        d.idx = IDX_W'(k);
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational target decode: which target (if any) owns an address.
module apb_addr_decode
  import apb_bridge_pkg::*;
#(
  parameter int                     TGT_N    = 4,
  parameter logic [TGT_N-1:0][31:0] TGT_BASE = {TGT_N{32'h0}},
  parameter logic [TGT_N-1:0][31:0] TGT_MASK = {TGT_N{32'h0}}
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  logic [TGT_MAX-1:0][31:0] base_pad;
  logic [TGT_MAX-1:0][31:0] mask_pad;
  dec_t                     dec;

  always_comb begin
    base_pad = '0;
    mask_pad = '0;
    for (int k = 0; k < TGT_N; k++) begin
      base_pad[k] = TGT_BASE[k];
      mask_pad[k] = TGT_MASK[k];
    end
    dec = addr_decode(addr, base_pad, mask_pad, TGT_N);
  end

  assign hit = dec.hit;
  assign idx = dec.idx;

endmodule

// File: rtl/apb_bridge_xbar.sv
// Registered APB 1-to-N bridge with decode-miss error and per-transfer timeout.
module apb_bridge_xbar
  import apb_bridge_pkg::*;
#(
  parameter int                     TGT_N    = 4,
  parameter logic [TGT_N-1:0][31:0] TGT_BASE = {TGT_N{32'h0}},
  parameter logic [TGT_N-1:0][31:0] TGT_MASK = {TGT_N{32'h0}},
  parameter int                     TIMEOUT  = 255,
  parameter int                     CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_psel,
  input  logic                  i_penable,
  input  logic [31:0]           i_paddr,
  input  logic                  i_pwrite,
  input  logic [31:0]           i_pwdata,
  input  logic [3:0]            i_pwstrb,
  output logic                  i_pready,
  output logic [31:0]           i_prdata,
  output logic                  i_pslverr,
  output logic [TGT_N-1:0]      t_psel,
  output logic                  t_penable,
  output logic [31:0]           t_paddr,
  output logic                  t_pwrite,
  output logic [31:0]           t_pwdata,
  output logic [3:0]            t_pwstrb,
  input  logic [TGT_N*32-1:0]   t_prdata,
  input  logic [TGT_N-1:0]      t_pready,
  input  logic [TGT_N-1:0]      t_pslverr,
  output logic [1:0]            err_pulse
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [TGT_N-1:0] sel_p0;
  logic [31:0]      addr_p0;
  logic             write_p0;
  logic [31:0]      wdata_p0;
  logic [3:0]       strb_p0;

  logic [31:0]      rdata_p1;
  logic             slverr_p1;
  logic [1:0]       err_p1;

  logic             dec_hit;
  logic [IDX_W-1:0] dec_idx;
  logic [TGT_N-1:0] dec_onehot;
  logic [31:0]      hit_mask;

  logic [31:0]      sel_rdata;
  logic             sel_ready;
  logic             sel_err;
  logic             tmo;

  // The initiator's enable phase carries no information this bridge needs.
  logic unused_penable;
  assign unused_penable = i_penable;

  apb_addr_decode #(
    .TGT_N    (TGT_N),
    .TGT_BASE (TGT_BASE),
    .TGT_MASK (TGT_MASK)
  ) u_decode (
    .addr (i_paddr),
    .hit  (dec_hit),
    .idx  (dec_idx)
  );

  always_comb begin
    dec_onehot = '0;
    hit_mask   = '0;
    for (int k = 0; k < TGT_N; k++) begin
      if (dec_hit && dec_idx == IDX_W'(k)) begin
        dec_onehot[k] = 1'b1;
        hit_mask      = TGT_MASK[k];
      end
    end
  end

  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int k = 0; k < TGT_N; k++) begin
      if (sel_p0[k]) begin
        sel_rdata = sel_rdata | t_prdata[k*32 +: 32];
        sel_ready = sel_ready | t_pready[k];
        sel_err   = sel_err   | t_pslverr[k];
      end
    end
  end

  assign tmo = (TIMEOUT != 0) && (cnt == TMO_LAST);

  // Request capture (p0) in IDLE; response registers (p1) loaded on entry to RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sel_p0    <= '0;
      addr_p0   <= '0;
      write_p0  <= 1'b0;
      wdata_p0  <= '0;
      strb_p0   <= '0;
      rdata_p1  <= '0;
      slverr_p1 <= 1'b0;
      err_p1    <= '0;
    end else begin
      err_p1 <= '0;
      case (state)
        IDLE: begin
          if (i_psel) begin
            addr_p0  <= i_paddr & hit_mask;
            write_p0 <= i_pwrite;
            wdata_p0 <= i_pwdata;
            strb_p0  <= i_pwstrb;
            sel_p0   <= dec_onehot;
            if (dec_hit) begin
              state <= T_SETUP;
            end else begin
              state            <= RESP;
              rdata_p1         <= '0;
              slverr_p1        <= 1'b1;
              err_p1[ERR_MISS] <= 1'b1;
            end
          end
        end
        T_SETUP: state <= T_ACCESS;
        T_ACCESS: begin
          cnt <= cnt + 1'b1;
          // A ready arriving on the timeout cycle still counts as a good response.
          if (sel_ready) begin
            state     <= RESP;
            rdata_p1  <= (write_p0 || sel_err) ? 32'h0 : sel_rdata;
            slverr_p1 <= sel_err;
          end else if (tmo) begin
            state           <= RESP;
            rdata_p1        <= '0;
            slverr_p1       <= 1'b1;
            err_p1[ERR_TMO] <= 1'b1;
          end
        end
        RESP: begin
          state     <= IDLE;
          cnt       <= '0;
          rdata_p1  <= '0;
          slverr_p1 <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign i_pready  = (state == RESP);
  assign i_prdata  = rdata_p1;
  assign i_pslverr = slverr_p1;
  assign err_pulse = err_p1;

  assign t_psel    = (state == T_SETUP || state == T_ACCESS) ? sel_p0 : '0;
  assign t_penable = (state == T_ACCESS);
  assign t_paddr   = addr_p0;
  assign t_pwrite  = write_p0;
  assign t_pwdata  = wdata_p0;
  assign t_pwstrb  = strb_p0;

endmodule

// File: tb/tb_apb_bridge_xbar.sv
// Bench for apb_bridge_xbar: transaction-level model, per-cycle compare, directed transfers.
module tb_apb_bridge_xbar;

  localparam int TGT_N   = 4;
  localparam int TIMEOUT = 8;
  localparam logic [TGT_N-1:0][31:0] BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h2000_0000};
  localparam logic [TGT_N-1:0][31:0] MASK =
    {32'h0000_FFFF, 32'h0000_00FF, 32'h0000_0FFF, 32'h0000_FFFF};

  logic                clk = 1'b0;
  logic                rst;
  logic                i_psel, i_penable, i_pwrite;
  logic [31:0]         i_paddr, i_pwdata;
  logic [3:0]          i_pwstrb;
  logic                i_pready, i_pslverr;
  logic [31:0]         i_prdata;
  logic [TGT_N-1:0]    t_psel;
  logic                t_penable, t_pwrite;
  logic [31:0]         t_paddr, t_pwdata;
  logic [3:0]          t_pwstrb;
  logic [TGT_N*32-1:0] t_prdata;
  logic [TGT_N-1:0]    t_pready, t_pslverr;
  logic [1:0]          err_pulse;

  apb_bridge_xbar #(
    .TGT_N(TGT_N), .TGT_BASE(BASE), .TGT_MASK(MASK), .TIMEOUT(TIMEOUT), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .i_psel(i_psel), .i_penable(i_penable), .i_paddr(i_paddr), .i_pwrite(i_pwrite),
    .i_pwdata(i_pwdata), .i_pwstrb(i_pwstrb), .i_pready(i_pready), .i_prdata(i_prdata),
    .i_pslverr(i_pslverr), .t_psel(t_psel), .t_penable(t_penable), .t_paddr(t_paddr),
    .t_pwrite(t_pwrite), .t_pwdata(t_pwdata), .t_pwstrb(t_pwstrb), .t_prdata(t_prdata),
    .t_pready(t_pready), .t_pslverr(t_pslverr), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Bench targets: wait states per target (-1 = never ready), optional error.
  int tgt_wait [TGT_N];
  bit tgt_err  [TGT_N];
  int acc_cnt = 0;

  function automatic logic [31:0] tgt_rdata(input int k, input logic [31:0] off);
    return 32'hA500_0000 | (32'(k) << 20) | {16'h0, off[15:0]};
  endfunction

  always @(posedge clk) begin
    if (t_penable && (|t_psel) && !(|t_pready)) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  always_comb begin
    t_pready  = '0;
    t_pslverr = '0;
    t_prdata  = '0;
    for (int k = 0; k < TGT_N; k++) begin
      t_prdata[k*32 +: 32] = tgt_rdata(k, t_paddr);
      if (t_psel[k] && t_penable && tgt_wait[k] >= 0 && acc_cnt == tgt_wait[k]) begin
        t_pready[k]  = 1'b1;
        t_pslverr[k] = tgt_err[k];
      end
    end
  end

  // Transaction model: expected response cycle and target-phase window of the current transfer.
  int          m_c0 = -100, m_resp = -100, m_tend = -100;
  logic [3:0]  m_sel = '0;
  logic [31:0] m_paddr = '0, m_wdata = '0, m_rdata = '0;
  logic [3:0]  m_strb = '0;
  logic        m_write = 1'b0, m_err = 1'b0;
  logic [1:0]  m_pulse = '0;

  task automatic model_start(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                             input logic [3:0] sb, input int c0);
    int hit, w;
    hit = -1;
    for (int k = TGT_N - 1; k >= 0; k--)
      if ((addr & ~MASK[k]) == BASE[k]) hit = k;
    m_c0 = c0; m_write = wr; m_wdata = wd; m_strb = sb;
    if (hit < 0) begin
      m_sel = '0; m_resp = c0 + 1; m_tend = -100;
      m_rdata = '0; m_err = 1'b1; m_pulse = 2'b01; m_paddr = '0;
    end else begin
      m_sel = 4'(1 << hit);
      m_paddr = addr & MASK[hit];
      w = tgt_wait[hit];
      if (w < 0 || w + 1 > TIMEOUT) begin
        m_resp = c0 + 2 + TIMEOUT; m_err = 1'b1; m_rdata = '0; m_pulse = 2'b10;
      end else begin
        m_resp = c0 + 3 + w; m_err = tgt_err[hit]; m_pulse = 2'b00;
        m_rdata = (wr || tgt_err[hit]) ? 32'h0 : tgt_rdata(hit, m_paddr);
      end
      m_tend = m_resp - 1;
    end
  endtask

  always @(posedge clk) begin
    bit in_t, in_a, at_r;
    #2;
    if (chk_en) begin
      at_r = (cyc == m_resp);
      in_t = (m_sel != 0) && cyc >= m_c0 + 1 && cyc <= m_tend;
      in_a = in_t && cyc >= m_c0 + 2;
      chk("i_pready", 32'(i_pready), 32'(at_r));
      chk("err_pulse", 32'(err_pulse), at_r ? 32'(m_pulse) : 32'h0);
      chk("t_psel", 32'(t_psel), in_t ? 32'(m_sel) : 32'h0);
      chk("t_penable", 32'(t_penable), 32'(in_a));
      if (at_r) begin
        chk("i_prdata", i_prdata, m_rdata);
        chk("i_pslverr", 32'(i_pslverr), 32'(m_err));
      end
      if (in_t) begin
        chk("t_paddr", t_paddr, m_paddr);
        chk("t_pwdata", t_pwdata, m_wdata);
        chk("t_pwstrb", 32'(t_pwstrb), 32'(m_strb));
        chk("t_pwrite", 32'(t_pwrite), 32'(m_write));
      end
    end
  end

  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input logic [3:0] sb, input bit drop, output int lat,
                      output logic [31:0] rd, output logic err, output logic [1:0] pulse);
    int c0;
    bit seen;
    @(negedge clk);
    i_psel = 1'b1; i_penable = 1'b0; i_paddr = addr;
    i_pwrite = wr; i_pwdata = wd; i_pwstrb = sb;
    c0 = cyc;
    model_start(addr, wr, wd, sb, c0);
    seen = 1'b0; lat = -1; rd = '0; err = 1'b0; pulse = '0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (drop) begin i_psel = 1'b0; i_penable = 1'b0; end
      else i_penable = 1'b1;
      if (i_pready) begin
        seen = 1'b1; lat = cyc - c0; rd = i_prdata; err = i_pslverr; pulse = err_pulse;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL pready_wait: no i_pready within 40 cycles of address 0x%h", addr);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      i_psel = 1'b0; i_penable = 1'b0;
    end
  endtask

  int          lat;
  logic [31:0] rd;
  logic        err;
  logic [1:0]  pulse;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < TGT_N; k++) begin tgt_wait[k] = 0; tgt_err[k] = 1'b0; end
    rst = 1'b1; i_psel = 1'b0; i_penable = 1'b0; i_paddr = '0;
    i_pwrite = 1'b0; i_pwdata = '0; i_pwstrb = '0;
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_psel", 32'(t_psel), 32'h0);
    chk("rst_pready", 32'(i_pready), 32'h0);
    chk("rst_prdata", i_prdata, 32'h0);
    chk("rst_paddr", t_paddr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Zero-wait read from target 1
    xfer(32'h1000_0010, 1'b0, 32'h0, 4'hF, 1'b0, lat, rd, err, pulse);
    chk("rd_lat", 32'(lat), 32'd3);
    chk("rd_data", rd, 32'hA510_0010);
    chk("rd_err", 32'(err), 32'd0);

    // Write with 3 wait states, back-to-back after the read
    tgt_wait[1] = 3;
    xfer(32'h1000_0004, 1'b1, 32'hDEAD_BEEF, 4'b0011, 1'b0, lat, rd, err, pulse);
    chk("wr_lat", 32'(lat), 32'd6);
    chk("wr_data", rd, 32'h0);
    chk("wr_err", 32'(err), 32'd0);
    tgt_wait[1] = 0;
    idle(1);

    // Decode miss
    xfer(32'h7000_0000, 1'b0, 32'h0, 4'hF, 1'b0, lat, rd, err, pulse);
    chk("miss_lat", 32'(lat), 32'd1);
    chk("miss_err", 32'(err), 32'd1);
    chk("miss_data", rd, 32'h0);
    chk("miss_pulse", 32'(pulse), 32'b01);

    // Dead target times out, next read to target 1 follows immediately
    tgt_wait[3] = -1;
    xfer(32'h3000_0020, 1'b0, 32'h0, 4'hF, 1'b0, lat, rd, err, pulse);
    chk("tmo_lat", 32'(lat), 32'd10);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_pulse", 32'(pulse), 32'b10);
    xfer(32'h1000_0100, 1'b0, 32'h0, 4'hF, 1'b0, lat, rd, err, pulse);
    chk("post_tmo_lat", 32'(lat), 32'd3);
    chk("post_tmo_data", rd, 32'hA510_0100);
    idle(1);

    // Overlapping targets 0 and 2: target 0 must win
    tgt_wait[0] = 1;
    xfer(32'h2000_0044, 1'b0, 32'h0, 4'hF, 1'b0, lat, rd, err, pulse);
    chk("ovl_lat", 32'(lat), 32'd4);
    chk("ovl_data", rd, 32'hA500_0044);

    // Ready on the last allowed access cycle beats the timeout
    tgt_wait[0] = TIMEOUT - 1;
    xfer(32'h2000_0008, 1'b0, 32'h0, 4'hF, 1'b0, lat, rd, err, pulse);
    chk("edge_lat", 32'(lat), 32'd10);
    chk("edge_err", 32'(err), 32'd0);
    chk("edge_data", rd, 32'hA500_0008);
    chk("edge_pulse", 32'(pulse), 32'b00);

    // Target-reported error on a read
    tgt_wait[0] = 0; tgt_err[0] = 1'b1;
    xfer(32'h2000_1000, 1'b0, 32'h0, 4'hF, 1'b0, lat, rd, err, pulse);
    chk("terr_err", 32'(err), 32'd1);
    chk("terr_data", rd, 32'h0);
    tgt_err[0] = 1'b0;
    idle(1);

    // Initiator drops psel mid-transfer; bridge still finishes
    tgt_wait[1] = 2;
    xfer(32'h1000_0ABC, 1'b1, 32'h1234_5678, 4'b1100, 1'b1, lat, rd, err, pulse);
    chk("drop_lat", 32'(lat), 32'd5);
    tgt_wait[1] = 0;
    idle(2);

    // Reset in T_ACCESS abandons the transfer
    @(negedge clk);
    i_psel = 1'b1; i_penable = 1'b0; i_paddr = 32'h3000_0000;
    i_pwrite = 1'b0; i_pwdata = 32'h0; i_pwstrb = 4'hF;
    model_start(32'h3000_0000, 1'b0, 32'h0, 4'hF, cyc);
    repeat (3) begin @(negedge clk); i_penable = 1'b1; end
    chk("pre_rst_penable", 32'(t_penable), 32'd1);
    rst = 1'b1; i_psel = 1'b0; i_penable = 1'b0;
    m_tend = cyc; m_resp = -100;
    @(negedge clk);
    chk("mid_rst_psel", 32'(t_psel), 32'h0);
    chk("mid_rst_penable", 32'(t_penable), 32'h0);
    chk("mid_rst_pready", 32'(i_pready), 32'h0);
    chk("mid_rst_paddr", t_paddr, 32'h0);
    rst = 1'b0;
    idle(1);
    xfer(32'h1000_0020, 1'b0, 32'h0, 4'hF, 1'b0, lat, rd, err, pulse);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_data", rd, 32'hA510_0020);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
